// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : wb_rr_arbiter
// Four-master Wishbone round-robin arbiter for one shared slave, with a
// per-strobe watchdog that force-terminates a stalled transfer.
// Rev    : 1.0
// ============================================================================
module wb_rr_arbiter #(
    parameter int TIMEOUT   = 255,
    parameter int ADR_WIDTH = 32
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,

    input  logic                 wb1_cyc_i,
    input  logic                 wb1_stb_i,
    input  logic                 wb1_we_i,
    input  logic [ADR_WIDTH-1:0] wb1_adr_i,
    input  logic [31:0]          wb1_dat_i,
    input  logic [3:0]           wb1_sel_i,
    output logic [31:0]          wb1_dat_o,
    output logic                 wb1_ack_o,

    input  logic                 wb2_cyc_i,
    input  logic                 wb2_stb_i,
    input  logic                 wb2_we_i,
    input  logic [ADR_WIDTH-1:0] wb2_adr_i,
    input  logic [31:0]          wb2_dat_i,
    input  logic [3:0]           wb2_sel_i,
    output logic [31:0]          wb2_dat_o,
    output logic                 wb2_ack_o,

    input  logic                 wb3_cyc_i,
    input  logic                 wb3_stb_i,
    input  logic                 wb3_we_i,
    input  logic [ADR_WIDTH-1:0] wb3_adr_i,
    input  logic [31:0]          wb3_dat_i,
    input  logic [3:0]           wb3_sel_i,
    output logic [31:0]          wb3_dat_o,
    output logic                 wb3_ack_o,

    input  logic                 wb4_cyc_i,
    input  logic                 wb4_stb_i,
    input  logic                 wb4_we_i,
    input  logic [ADR_WIDTH-1:0] wb4_adr_i,
    input  logic [31:0]          wb4_dat_i,
    input  logic [3:0]           wb4_sel_i,
    output logic [31:0]          wb4_dat_o,
    output logic                 wb4_ack_o,

    output logic                 wbowner_cyc_o,
    output logic                 wbowner_stb_o,
    output logic                 wbowner_we_o,
    output logic [ADR_WIDTH-1:0] wbowner_adr_o,
    output logic [31:0]          wbowner_dat_o,
    output logic [3:0]           wbowner_sel_o,
    input  logic [31:0]          wbowner_dat_i,
    input  logic                 wbowner_ack_i,

    output logic [1:0]           grant_o,
    output logic                 timeout_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_OWNED   = 2'd1;
    localparam logic [1:0] S_FLUSH   = 2'd2;
    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    logic [1:0]           state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic [1:0]           last_q,  last_d;
    logic [7:0]           wdog_q,  wdog_d;

    logic [3:0]           w_cyc, w_stb, w_we;
    logic [ADR_WIDTH-1:0] w_adr  [4];
    logic [31:0]          w_dat  [4];
    logic [3:0]           w_sel  [4];
    logic [3:0]           w_ack;
    logic [31:0]          w_mdat [4];
    logic                 w_own_cyc, w_own_stb;
    logic [1:0]           w_base;
    logic [2:0]           w_pick;

    // Returns {found, index} of the first requester strictly after 'from'.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] from);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = from + 2'(k);
            if (req[idx]) begin
                rr_pick = {1'b1, idx};
            end
        end
    endfunction

    assign w_cyc = {wb4_cyc_i, wb3_cyc_i, wb2_cyc_i, wb1_cyc_i};
    assign w_stb = {wb4_stb_i, wb3_stb_i, wb2_stb_i, wb1_stb_i};
    assign w_we  = {wb4_we_i,  wb3_we_i,  wb2_we_i,  wb1_we_i};

    assign w_adr[0] = wb1_adr_i;
    assign w_adr[1] = wb2_adr_i;
    assign w_adr[2] = wb3_adr_i;
    assign w_adr[3] = wb4_adr_i;
    assign w_dat[0] = wb1_dat_i;
    assign w_dat[1] = wb2_dat_i;
    assign w_dat[2] = wb3_dat_i;
    assign w_dat[3] = wb4_dat_i;
    assign w_sel[0] = wb1_sel_i;
    assign w_sel[1] = wb2_sel_i;
    assign w_sel[2] = wb3_sel_i;
    assign w_sel[3] = wb4_sel_i;

    assign w_own_cyc = w_cyc[grant_q];
    assign w_own_stb = w_stb[grant_q];

    assign wbowner_cyc_o = (state_q != S_IDLE) && w_own_cyc;
    assign wbowner_stb_o = (state_q == S_OWNED) && w_own_stb;
    assign wbowner_we_o  = w_we[grant_q];
    assign wbowner_adr_o = w_adr[grant_q];
    assign wbowner_dat_o = w_dat[grant_q];
    assign wbowner_sel_o = w_sel[grant_q];

    assign grant_o   = grant_q;
    assign timeout_o = (state_q == S_FLUSH);

    // A forced termination substitutes its own ack and dropping any late slave ack.
    always_comb begin
        w_ack = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            w_mdat[n] = wbowner_dat_i;
        end
        if (state_q == S_OWNED) begin
            w_ack[grant_q] = wbowner_ack_i;
        end else if (state_q == S_FLUSH) begin
            w_ack[grant_q]  = 1'b1;
            w_mdat[grant_q] = 32'hFFFF_FFFF;
        end
    end

    assign wb1_ack_o = w_ack[0];
    assign wb2_ack_o = w_ack[1];
    assign wb3_ack_o = w_ack[2];
    assign wb4_ack_o = w_ack[3];
    assign wb1_dat_o = w_mdat[0];
    assign wb2_dat_o = w_mdat[1];
    assign wb3_dat_o = w_mdat[2];
    assign wb4_dat_o = w_mdat[3];

    assign w_base = (state_q == S_IDLE) ? last_q : grant_q;
    assign w_pick = rr_pick(w_cyc, w_base);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        case (state_q)
            S_IDLE: begin
                wdog_d = 8'd0;
                if (w_pick[2]) begin
                    grant_d = w_pick[1:0];
                    state_d = S_OWNED;
                end
            end
            S_OWNED: begin
                if (!w_own_cyc) begin
                    // Release: the owner's cyc is low, so rr_pick skips it naturally.
                    last_d = grant_q;
                    wdog_d = 8'd0;
                    if (w_pick[2]) begin
                        grant_d = w_pick[1:0];
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (wbowner_ack_i || !w_own_stb) begin
                        wdog_d = 8'd0;
                    end else if (wdog_q != 8'hFF) begin
                        wdog_d = wdog_q + 8'd1;
                    end
                    if (wdog_d == C_TIMEOUT) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                wdog_d  = 8'd0;
                state_d = S_OWNED;
            end
            default: begin
                wdog_d  = 8'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            grant_q <= 2'd0;
            last_q  <= 2'd3;
            wdog_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_rr_arbiter
// Self-checking bench for wb_rr_arbiter: vector table, directed corner cases
// and randomized traffic against a behavioural arbitration model.
// Rev    : 1.0
// ============================================================================
module tb_wb_rr_arbiter;

    localparam int TMO = 4;

    typedef struct {
        logic [3:0] cyc;
        logic [3:0] stb;
        logic       sack;
        logic [1:0] g;
        logic [3:0] acks;
        logic       oc;
        logic       os;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cyc, stb, we;
    logic [31:0] adr  [4];
    logic [31:0] wdat [4];
    logic [3:0]  sel  [4];
    logic        s_ack;
    logic [31:0] s_dat;

    wire  [3:0]  ack;
    wire  [31:0] dato [4];
    wire         oc, os, owe, tmo;
    wire  [31:0] oadr, odat;
    wire  [3:0]  osel;
    wire  [1:0]  grant;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter #(.TIMEOUT(TMO), .ADR_WIDTH(32)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wb1_cyc_i(cyc[0]), .wb1_stb_i(stb[0]), .wb1_we_i(we[0]), .wb1_adr_i(adr[0]),
        .wb1_dat_i(wdat[0]), .wb1_sel_i(sel[0]), .wb1_dat_o(dato[0]), .wb1_ack_o(ack[0]),
        .wb2_cyc_i(cyc[1]), .wb2_stb_i(stb[1]), .wb2_we_i(we[1]), .wb2_adr_i(adr[1]),
        .wb2_dat_i(wdat[1]), .wb2_sel_i(sel[1]), .wb2_dat_o(dato[1]), .wb2_ack_o(ack[1]),
        .wb3_cyc_i(cyc[2]), .wb3_stb_i(stb[2]), .wb3_we_i(we[2]), .wb3_adr_i(adr[2]),
        .wb3_dat_i(wdat[2]), .wb3_sel_i(sel[2]), .wb3_dat_o(dato[2]), .wb3_ack_o(ack[2]),
        .wb4_cyc_i(cyc[3]), .wb4_stb_i(stb[3]), .wb4_we_i(we[3]), .wb4_adr_i(adr[3]),
        .wb4_dat_i(wdat[3]), .wb4_sel_i(sel[3]), .wb4_dat_o(dato[3]), .wb4_ack_o(ack[3]),
        .wbowner_cyc_o(oc), .wbowner_stb_o(os), .wbowner_we_o(owe), .wbowner_adr_o(oadr),
        .wbowner_dat_o(odat), .wbowner_sel_o(osel), .wbowner_dat_i(s_dat),
        .wbowner_ack_i(s_ack), .grant_o(grant), .timeout_o(tmo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        cyc   = 4'b0000;
        stb   = 4'b0000;
        we    = 4'b0000;
        s_ack = 1'b0;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_ocyc",  64'(oc),    64'd0);
        chk("rst_ostb",  64'(os),    64'd0);
        chk("rst_acks",  64'(ack),   64'd0);
        chk("rst_tmo",   64'(tmo),   64'd0);
        rst = 1'b0;
    endtask

    // First requester strictly after 'from' in rotating order.
    function automatic int next_req(input logic [3:0] req, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (req[(from + k) % 4]) return (from + k) % 4;
        end
        return from;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got hang want finish");
        $fatal(1);
    end

    initial begin
        vec_t        vt [14];
        int          order[$];
        int          nack [4];
        bit          dropped [4];
        int          cur, n_stb;
        bit          seen;
        int          m_owner, m_last, m_stall;
        bit          m_busy, m_flush;
        logic [3:0]  e_acks;
        logic        e_oc, e_os, e_to;
        logic [31:0] e_dat;

        for (int m = 0; m < 4; m++) begin
            adr[m]  = 32'h1000 * (m + 1);
            wdat[m] = 32'h1111_1111 * (m + 1);
            sel[m]  = 4'hF;
        end
        s_dat = 32'h1234_5678;

        vt[0]  = '{4'b0101, 4'b0101, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        vt[1]  = '{4'b0101, 4'b0101, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1};
        vt[2]  = '{4'b0100, 4'b0100, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        vt[3]  = '{4'b0100, 4'b0100, 1'b0, 2'd2, 4'b0000, 1'b1, 1'b1};
        vt[4]  = '{4'b0101, 4'b0100, 1'b0, 2'd2, 4'b0000, 1'b1, 1'b1};
        vt[5]  = '{4'b0001, 4'b0000, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b0};
        vt[6]  = '{4'b0001, 4'b0001, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1};
        vt[7]  = '{4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        vt[8]  = '{4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        vt[9]  = '{4'b1001, 4'b1001, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        vt[10] = '{4'b1001, 4'b1000, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1};
        vt[11] = '{4'b0001, 4'b0001, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b0};
        vt[12] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        vt[13] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            cyc   = vt[i].cyc;
            stb   = vt[i].stb;
            s_ack = vt[i].sack;
            #3;
            chk($sformatf("vec%0d_grant", i), 64'(grant), 64'(vt[i].g));
            chk($sformatf("vec%0d_acks", i),  64'(ack),   64'(vt[i].acks));
            chk($sformatf("vec%0d_ocyc", i),  64'(oc),    64'(vt[i].oc));
            chk($sformatf("vec%0d_ostb", i),  64'(os),    64'(vt[i].os));
            @(posedge clk); #1;
        end

        // Master 2 write routed to the slave side.
        do_reset();
        cyc = 4'b1111 & 4'b0010; stb = 4'b0010; we = 4'b0010;
        adr[1] = 32'h10; wdat[1] = 32'hA5A5_A5A5; sel[1] = 4'b0011;
        #3;
        chk("w2_idle_ocyc", 64'(oc), 64'd0);
        @(posedge clk); #1;
        s_ack = 1'b1;
        #3;
        chk("w2_grant", 64'(grant), 64'd1);
        chk("w2_ocyc",  64'(oc),    64'd1);
        chk("w2_owe",   64'(owe),   64'd1);
        chk("w2_oadr",  64'(oadr),  64'h10);
        chk("w2_odat",  64'(odat),  64'hA5A5_A5A5);
        chk("w2_osel",  64'(osel),  64'b0011);
        chk("w2_acks",  64'(ack),   64'b0010);
        @(posedge clk); #1;
        cyc = 4'b0000; stb = 4'b0000; we = 4'b0000; s_ack = 1'b0;

        // Watchdog: slave never acks.
        do_reset();
        cyc = 4'b0001; stb = 4'b0001; s_dat = 32'h1234_5678;
        n_stb = 0; seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            #3;
            if (tmo) begin
                seen = 1'b1;
            end else begin
                if (os) n_stb++;
                @(posedge clk); #1;
            end
        end
        chk("tmo_seen", 64'(seen), 64'd1);
        chk("tmo_stb_cycles", 64'(n_stb), 64'(TMO));
        s_ack = 1'b1;
        #1;
        chk("tmo_acks", 64'(ack),     64'b0001);
        chk("tmo_dat",  64'(dato[0]), 64'hFFFF_FFFF);
        chk("tmo_ostb", 64'(os),      64'd0);
        @(posedge clk); #1;
        s_ack = 1'b0;
        #3;
        chk("tmo_pulse_end", 64'(tmo), 64'd0);
        chk("tmo_ostb_back", 64'(os),  64'd1);
        chk("tmo_noack",     64'(ack), 64'd0);

        // Reset in the middle of a master 4 burst.
        do_reset();
        cyc = 4'b1000; stb = 4'b1000; s_ack = 1'b1;
        @(posedge clk); #1;
        #3;
        chk("w4_grant", 64'(grant), 64'd3);
        chk("w4_ack",   64'(ack),   64'b1000);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstmid_acks",  64'(ack),   64'd0);
        chk("rstmid_ocyc",  64'(oc),    64'd0);
        chk("rstmid_grant", 64'(grant), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; cyc = 4'b1010; stb = 4'b1010;
        #3;
        chk("postrst_idle", 64'(oc), 64'd0);
        @(posedge clk); #1;
        chk("postrst_grant", 64'(grant), 64'd1);
        cyc = 4'b0000; stb = 4'b0000; s_ack = 1'b0;

        // Four continuous requesters, each takes two acks then releases.
        do_reset();
        s_ack = 1'b1;
        for (int m = 0; m < 4; m++) begin nack[m] = 0; dropped[m] = 1'b0; end
        cur = -1;
        for (int c = 0; c < 80 && order.size() < 5; c++) begin
            for (int m = 0; m < 4; m++) begin
                if (nack[m] >= 2) begin
                    if (dropped[m]) begin nack[m] = 0; dropped[m] = 1'b0; end
                    else dropped[m] = 1'b1;
                end
                cyc[m] = (nack[m] < 2);
                stb[m] = cyc[m];
            end
            #3;
            if (oc && int'(grant) != cur) begin
                order.push_back(int'(grant));
                cur = int'(grant);
            end
            if (oc && ack[grant]) nack[grant]++;
            @(posedge clk); #1;
        end
        chk("fair_count", 64'(order.size()), 64'd5);
        for (int i = 0; i < order.size(); i++) begin
            chk($sformatf("fair_order%0d", i), 64'(order[i]), 64'(i % 4));
        end

        // Randomized traffic against the behavioural model.
        do_reset();
        m_owner = 0; m_last = 3; m_stall = 0; m_busy = 1'b0; m_flush = 1'b0;
        for (int c = 0; c < 500; c++) begin
            for (int m = 0; m < 4; m++) begin
                if ($urandom_range(0, 4) == 0) cyc[m] = ~cyc[m];
                stb[m] = cyc[m] & ($urandom_range(0, 3) != 0);
                we[m]  = 1'($urandom_range(0, 1));
            end
            s_ack = ($urandom_range(0, 2) == 0);
            s_dat = $urandom;

            e_acks = 4'b0000; e_oc = 1'b0; e_os = 1'b0; e_to = 1'b0; e_dat = s_dat;
            if (m_busy) begin
                e_oc = cyc[m_owner];
                if (m_flush) begin
                    e_acks[m_owner] = 1'b1; e_to = 1'b1; e_dat = 32'hFFFF_FFFF;
                end else begin
                    e_os = stb[m_owner];
                    e_acks[m_owner] = s_ack;
                end
            end
            #3;
            chk("rnd_grant", 64'(grant), 64'(m_owner));
            chk("rnd_acks",  64'(ack),   64'(e_acks));
            chk("rnd_ocyc",  64'(oc),    64'(e_oc));
            chk("rnd_ostb",  64'(os),    64'(e_os));
            chk("rnd_tmo",   64'(tmo),   64'(e_to));
            chk("rnd_dat",   64'(dato[m_owner]), 64'(e_dat));

            if (m_flush) begin
                m_flush = 1'b0; m_stall = 0;
            end else if (!m_busy) begin
                if (|cyc) begin m_owner = next_req(cyc, m_last); m_busy = 1'b1; end
            end else if (!cyc[m_owner]) begin
                m_last = m_owner; m_stall = 0;
                if (|cyc) m_owner = next_req(cyc, m_owner);
                else m_busy = 1'b0;
            end else begin
                if (s_ack || !stb[m_owner]) m_stall = 0;
                else if (m_stall < 255) m_stall++;
                if (m_stall == TMO) m_flush = 1'b1;
            end
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning owner-side cycles allowed per strobe before forced termination (1..255).
REQ-002 SHALL have parameter ADR_WIDTH, default 32, meaning master/owner address width.
REQ-003 SHALL have port wb_clk_i, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have ports wbN_cyc_i / wbN_stb_i / wbN_we_i (N=1..4), input, 1 each, master N bus cycle/strobe/write.
REQ-006 SHALL have ports wbN_adr_i, input, ADR_WIDTH; wbN_dat_i, input, 32; wbN_sel_i, input, 4; master N address/write data/byte selects.
REQ-007 SHALL have ports wbN_dat_o, output, 32; wbN_ack_o, output, 1; master N read data and acknowledge.
REQ-008 SHALL have ports wbowner_cyc_o / wbowner_stb_o / wbowner_we_o, output, 1 each; wbowner_adr_o, output, ADR_WIDTH; wbowner_dat_o, output, 32; wbowner_sel_o, output, 4; shared-slave side.
REQ-009 SHALL have ports wbowner_dat_i, input, 32; wbowner_ack_i, input, 1; shared-slave read data and acknowledge.
REQ-010 SHALL have port grant_o, output, 2, index of current owner (0..3 = master 1..4); timeout_o, output, 1, one-cycle pulse on forced termination.

Function
REQ-011 SHALL implement FSM states IDLE, OWNED, FLUSH.
REQ-012 IDLE: no owner; wbowner_cyc_o=0, wbowner_stb_o=0; on any wbN_cyc_i=1 SHALL register grant to the first requester found searching upward from (last_grant+1) mod 4, then enter OWNED next cycle.
REQ-013 Grant latency SHALL be exactly one clock from first sampled cyc to owner-side cyc assertion.
REQ-014 OWNED: wbowner_cyc/stb/we/adr/dat/sel_o SHALL be a combinational mux of the granted master's inputs; other masters' inputs SHALL be ignored.
REQ-015 OWNED: wbowner_ack_i SHALL route combinationally to the granted master's ack; wbowner_dat_i SHALL route to every wbN_dat_o (only owner's ack qualifies it).
REQ-016 Non-granted masters SHALL see ack=0 at all times.
REQ-017 Grant SHALL be held while granted master's cyc=1 (multi-strobe bursts and read-modify-write stay atomic).
REQ-018 When granted cyc samples 0, SHALL update last_grant to the owner and re-arbitrate in the same cycle: another requester present -> OWNED with new grant next cycle; none -> IDLE.
REQ-019 Watchdog: 8-bit counter SHALL clear on every owner-side ack and whenever owner stb=0, increment each cycle owner stb=1 without ack, saturating.
REQ-020 On counter reaching TIMEOUT SHALL enter FLUSH: one cycle driving owner ack=1 and wbN_dat_o=32'hFFFFFFFF to the granted master, wbowner_stb_o=0, timeout_o=1; then return to OWNED.
REQ-021 FLUSH: a late wbowner_ack_i SHALL be dropped, not forwarded.
REQ-022 Simultaneous requests SHALL resolve by rotating priority only; a master requesting continuously SHALL be granted within 3 other ownerships.
REQ-023 Owner dropping cyc on the same cycle as ack SHALL complete that ack and release per REQ-018.
REQ-024 grant_o SHALL hold the last owner while IDLE.

Reset
REQ-025 Asserting wb_rst_i SHALL immediately (asynchronously) force IDLE, grant_o=0, last_grant=3 (so master 1 has first priority), watchdog=0, timeout_o=0.
REQ-026 While in reset all wbN_ack_o=0, wbowner_cyc_o=0, wbowner_stb_o=0; reset mid-transfer SHALL abandon it without ack.
REQ-027 First arbitration after reset deassertion SHALL occur on the first rising edge with wb_rst_i=0.

Verification
REQ-028 Reset release, wb1 and wb3 assert cyc same cycle -> grant_o=0 next cycle; after wb1 drops cyc, grant_o=2 one cycle later.
REQ-029 All four request continuously, each holds cyc for 2 acks -> grant order 1,2,3,4,1, no master starved.
REQ-030 wb2 write adr=0x10 dat=0xA5A5A5A5 sel=4'b0011 -> owner-side outputs equal these values; slave ack routed to wb2_ack_o only.
REQ-031 TIMEOUT=4, slave never acks -> after 4 owner stb cycles wb owner's ack=1 with dat 0xFFFFFFFF and timeout_o pulse of 1 cycle.
REQ-032 Assert wb_rst_i mid-burst of wb4 -> all acks 0 and wbowner_cyc_o=0 before next clock edge; after release, wb4 re-request granted only after master 1..3 priority check.
REQ-033 wb3 drops cyc in same cycle as slave ack with wb1 waiting -> wb3 receives ack, grant_o=0 next cycle.
